p_mul_iter: RTL and testbench

P_MUL_ITER -- requirements
Module: p_mul_iter

---
 rtl/p_mul_iter_if.sv | 19 +
 rtl/p_mul_iter.sv | 152 +++++++++++++++
 tb/tb_p_mul_iter.sv | 114 +++++++++++
 3 files changed

// File: rtl/p_mul_iter_if.sv
// Request/response bundle for the iterative packed multiplier p_mul_iter.
interface p_mul_iter_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic            ready;
  logic            mul_l;
  logic            mul_h;
  logic            clmul;
  logic [5:0]      pw;
  logic [XLEN-1:0] crs1;
  logic [XLEN-1:0] crs2;
  logic [XLEN-1:0] result;

  modport master (output valid, mul_l, mul_h, clmul, pw, crs1, crs2,
                  input  ready, result);
  modport slave  (input  valid, mul_l, mul_h, clmul, pw, crs1, crs2,
                  output ready, result);
endinterface

// File: rtl/p_mul_iter.sv
// Iterative packed-lane multiplier: one shift-add step per clock over W-bit lanes.
// Define P_MUL_ITER_CLMUL_EN to build the carryless (XOR) accumulation path.
module p_mul_iter #(
  parameter int XLEN = 32
) (
  input  logic       clock,
  input  logic       reset,
  p_mul_iter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t            state_r, state_s;
  logic [5:0]        cnt_r, cnt_s;
  logic [2*XLEN-1:0] psum_r, psum_s;
  logic [XLEN-1:0]   result_r, result_s;
  logic              ready_r, ready_s;

  logic [2*XLEN-1:0] step_s [6];
  logic [XLEN-1:0]   res_s  [6];
  logic [2*XLEN-1:0] sel_step_s;
  logic [XLEN-1:0]   sel_res_s;
  logic [5:0]        wm1_s;
  logic              legal_s;
  logic              last_s;

  // Per-width lane arrays; each lane keeps its own 2W-bit product inside psum_r.
  for (genvar g = 0; g < 6; g++) begin : g_w
    localparam int W = 64 >> g;
    if (W <= XLEN) begin : g_on
      for (genvar j = 0; j < XLEN / W; j++) begin : g_lane
        logic [W-1:0]   a_s, b_sh_s;
        logic [2*W-1:0] prod_s, add_s, nxt_s;
        assign a_s    = bus.crs1[W*j +: W];
        assign b_sh_s = bus.crs2[W*j +: W] >> cnt_r;
        assign prod_s = psum_r[2*W*j +: 2*W];
        assign add_s  = {{W{1'b0}}, a_s} << cnt_r;
`ifdef P_MUL_ITER_CLMUL_EN
        assign nxt_s  = !b_sh_s[0] ? prod_s :
                        (bus.clmul ? (prod_s ^ add_s) : (prod_s + add_s));
`else
        assign nxt_s  = !b_sh_s[0] ? prod_s : (prod_s + add_s);
`endif
        assign step_s[g][2*W*j +: 2*W] = nxt_s;
        assign res_s[g][W*j +: W]      = bus.mul_h ? nxt_s[2*W-1:W] : nxt_s[W-1:0];
      end
    end else begin : g_off
      assign step_s[g] = '0;
      assign res_s[g]  = '0;
    end
  end

  // Lane-width decode: selects the active width's step result and final step index.
  always_comb begin
    sel_step_s = '0;
    sel_res_s  = '0;
    wm1_s      = 6'd0;
    legal_s    = 1'b1;
    case (bus.pw)
      6'b000001: begin sel_step_s = step_s[0]; sel_res_s = res_s[0]; wm1_s = 6'd63;
                       legal_s = (XLEN == 64); end
      6'b000010: begin sel_step_s = step_s[1]; sel_res_s = res_s[1]; wm1_s = 6'd31; end
      6'b000100: begin sel_step_s = step_s[2]; sel_res_s = res_s[2]; wm1_s = 6'd15; end
      6'b001000: begin sel_step_s = step_s[3]; sel_res_s = res_s[3]; wm1_s = 6'd7;  end
      6'b010000: begin sel_step_s = step_s[4]; sel_res_s = res_s[4]; wm1_s = 6'd3;  end
      6'b100000: begin sel_step_s = step_s[5]; sel_res_s = res_s[5]; wm1_s = 6'd1;  end
      default:   legal_s = 1'b0;
    endcase
  end

  assign last_s = legal_s ? (cnt_r == wm1_s) : 1'b1;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; dropping valid while busy abandons the operation.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = bus.valid ? BUSY : IDLE;
      BUSY: begin
        if (!bus.valid) begin
          state_s = IDLE;
        end else if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath and output next values; illegal widths finish on their first busy edge with 0.
  always_comb begin
    cnt_s    = cnt_r;
    psum_s   = psum_r;
    result_s = result_r;
    ready_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.valid) begin
          cnt_s  = 6'd0;
          psum_s = '0;
        end else begin
          cnt_s  = cnt_r;
        end
      end
      BUSY: begin
        if (!bus.valid) begin
          cnt_s = cnt_r;
        end else if (!legal_s) begin
          result_s = '0;
          ready_s  = 1'b1;
        end else if (last_s) begin
          psum_s   = sel_step_s;
          result_s = sel_res_s;
          ready_s  = 1'b1;
        end else begin
          psum_s = sel_step_s;
          cnt_s  = cnt_r + 6'd1;
        end
      end
      DONE:    ready_s = 1'b0;
      default: ready_s = 1'b0;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r    <= 6'd0;
      psum_r   <= '0;
      result_r <= '0;
      ready_r  <= 1'b0;
    end else begin
      cnt_r    <= cnt_s;
      psum_r   <= psum_s;
      result_r <= result_s;
      ready_r  <= ready_s;
    end
  end

  assign bus.ready  = ready_r;
  assign bus.result = result_r;
endmodule

// File: tb/tb_p_mul_iter.sv
// Directed self-checking bench for p_mul_iter at XLEN=32.
module tb_p_mul_iter;
  logic clock;
  logic reset;
  int   tests;
  int   fails;

  p_mul_iter_if #(.XLEN(32)) bus ();
  p_mul_iter #(.XLEN(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation, measure edges from acceptance to ready, check result and pulse width.
  task automatic run_op(input string tag, input logic [5:0] pw, input logic h, input logic l,
                        input logic c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int edges;
    bus.valid = 1'b1; bus.pw = pw; bus.mul_h = h; bus.mul_l = l; bus.clmul = c;
    bus.crs1 = a; bus.crs2 = b;
    @(posedge clock); #1;
    edges = 0;
    while (!bus.ready && edges < 100) begin
      @(posedge clock); #1;
      edges++;
    end
    bus.valid = 1'b0;
    check({tag, "_lat"}, 32'(edges), 32'(lat));
    check({tag, "_res"}, bus.result, exp);
    @(posedge clock); #1;
    check({tag, "_pulse"}, {31'd0, bus.ready}, 32'd0);
  endtask

  initial begin
    int seen;
    tests = 0; fails = 0;
    reset = 1'b1;
    bus.valid = 1'b0; bus.pw = 6'b000010; bus.mul_h = 1'b0; bus.mul_l = 1'b0;
    bus.clmul = 1'b0; bus.crs1 = 32'd0; bus.crs2 = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_op("w32_lo", 6'b000010, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32);
    run_op("w32_hi", 6'b000010, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32);
    run_op("w16_lo", 6'b000100, 1'b0, 1'b1, 1'b0, 32'h00030005, 32'h00070009, 32'h0015002D, 16);
    run_op("w8_hi",  6'b001000, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h02020202, 32'h01010101, 8);
`ifdef P_MUL_ITER_CLMUL_EN
    run_op("clmul",  6'b000010, 1'b0, 1'b1, 1'b1, 32'h00000003, 32'h00000003, 32'h00000005, 32);
`else
    run_op("clmul",  6'b000010, 1'b0, 1'b1, 1'b1, 32'h00000003, 32'h00000003, 32'h00000009, 32);
`endif
    run_op("w4_none", 6'b010000, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h11111111, 4);
    run_op("w4_both", 6'b010000, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEEEEEEEE, 4);
    run_op("ill_zero", 6'b000000, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1);
    run_op("w16_b",  6'b000100, 1'b0, 1'b1, 1'b0, 32'h00030005, 32'h00070009, 32'h0015002D, 16);
    run_op("ill_multi", 6'b000110, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1);
    run_op("w8_lo",  6'b001000, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h02020202, 32'hFEFEFEFE, 8);
    run_op("ill_w64", 6'b000001, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1);
    run_op("w16_c",  6'b000100, 1'b0, 1'b1, 1'b0, 32'h00030005, 32'h00070009, 32'h0015002D, 16);

    // Abort: drop valid after 5 busy edges; no ready may follow and result must hold.
    bus.valid = 1'b1; bus.pw = 6'b000010; bus.mul_l = 1'b1; bus.mul_h = 1'b0;
    bus.crs1 = 32'hFFFFFFFF; bus.crs2 = 32'hFFFFFFFF;
    @(posedge clock); #1;
    repeat (5) @(posedge clock);
    #1;
    bus.valid = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (bus.ready) seen++;
    end
    check("abort_noready", 32'(seen), 32'd0);
    check("abort_hold", bus.result, 32'h0015002D);
    run_op("w2_after", 6'b100000, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 2);

    // Reset mid-busy clears outputs without a clock edge and leaves the FSM idle.
    bus.valid = 1'b1; bus.pw = 6'b000010; bus.mul_l = 1'b1;
    bus.crs1 = 32'h00000007; bus.crs2 = 32'h00000003;
    @(posedge clock); #1;
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_ready", {31'd0, bus.ready}, 32'd0);
    check("midrst_result", bus.result, 32'd0);
    bus.valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (bus.ready) seen++;
    end
    check("midrst_noready", 32'(seen), 32'd0);
    check("midrst_result2", bus.result, 32'd0);
    run_op("post_rst", 6'b001000, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h02020202, 32'h01010101, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
